// File: rtl/hv_encoder_seq.sv
// hv_encoder_seq
//   Micro-instruction sequencer for the HV encoder datapath. A small
//   instruction store holds packed encoder control words. After start_i the
//   program is issued one word per cycle from pc 0 to prog_end. One hardware
//   loop repeats the body [loop_start, loop_end] loop_num times. Words whose
//   consume flag is set pop one item address from the valid/ready stream and
//   present it on im_addr_o together with the control word.
//
//   Optional feature (compile-time macro HV_ENCODER_SEQ_ABORT_EN): adds the
//   abort_i input. While running, abort_i returns the sequencer to idle on
//   the next edge, without issuing and without a done_o pulse.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cfg_wr_*             instruction store write port (idle only)
//   loop_start_i/loop_end_i/loop_num_i/prog_end_i
//                        program bounds, latched on start_i
//   start_i              start program (idle only)
//   busy_o               sequencer running
//   done_o               one-cycle pulse alongside the last issued word
//   data_valid_i/data_ready_o/data_i
//                        item address stream
//   ctrl_o/ctrl_valid_o  registered control word and its valid
//   im_addr_o            registered item-memory address
//   abort_i              (HV_ENCODER_SEQ_ABORT_EN only) abort the run
`timescale 1ns/1ps
module hv_encoder_seq #(
   parameter int CtrlWidth     = 32,
   parameter int NumInstr      = 16,
   parameter int ImAddrWidth   = 32,
   parameter int LoopCntWidth  = 16,
   parameter int InstAddrWidth = $clog2(NumInstr),
   parameter int InstWidth     = CtrlWidth + 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cfg_wr_en_i,
   input  logic [InstAddrWidth-1:0] cfg_wr_addr_i,
   input  logic [InstWidth-1:0]     cfg_wr_data_i,
   input  logic [InstAddrWidth-1:0] loop_start_i,
   input  logic [InstAddrWidth-1:0] loop_end_i,
   input  logic [LoopCntWidth-1:0]  loop_num_i,
   input  logic [InstAddrWidth-1:0] prog_end_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
`ifdef HV_ENCODER_SEQ_ABORT_EN
   input  logic                     abort_i,
`endif
   input  logic                     data_valid_i,
   output logic                     data_ready_o,
   input  logic [ImAddrWidth-1:0]   data_i,
   output logic [CtrlWidth-1:0]     ctrl_o,
   output logic                     ctrl_valid_o,
   output logic [ImAddrWidth-1:0]   im_addr_o
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   logic [0:0]               state_q;
   logic [InstAddrWidth-1:0] pc_q;
   logic [LoopCntWidth-1:0]  iter_q;
   logic [InstAddrWidth-1:0] loop_start_q;
   logic [InstAddrWidth-1:0] loop_end_q;
   logic [LoopCntWidth-1:0]  loop_num_q;
   logic [InstAddrWidth-1:0] prog_end_q;

   logic [InstWidth-1:0]     inst_store [NumInstr];

   logic [InstWidth-1:0]     inst;
   logic                     consume;
   logic [CtrlWidth-1:0]     ctrl_word;
   logic                     running;
   logic                     abort_req;
   logic                     issue;
   logic                     take_loop;
   logic [LoopCntWidth:0]    iter_inc;
   logic [LoopCntWidth-1:0]  loop_max;
   logic [InstAddrWidth-1:0] pc_inc;

`ifdef HV_ENCODER_SEQ_ABORT_EN
   assign abort_req = abort_i;
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      inst      = inst_store[pc_q];
      consume   = inst[CtrlWidth];
      ctrl_word = inst[CtrlWidth-1:0];
      running   = (state_q == StRun);
      // Abort wins over issue, so the stream is not acknowledged either.
      issue        = running && !abort_req && (!consume || data_valid_i);
      data_ready_o = running && !abort_req && consume;
      // loop_num of zero behaves as one pass through the body; the compare
      // is one bit wider so iter+1 cannot overflow.
      loop_max  = (loop_num_q == '0) ? LoopCntWidth'(1) : loop_num_q;
      iter_inc  = {1'b0, iter_q} + 1'b1;
      take_loop = (pc_q == loop_end_q) && (iter_inc < {1'b0, loop_max});
      // Explicit wrap keeps non-power-of-two store depths in range.
      pc_inc    = (pc_q == InstAddrWidth'(NumInstr - 1)) ? '0 : pc_q + 1'b1;
   end

   // Instruction store: written only while idle, never reset.
   always_ff @(posedge clk_i) begin
      if (cfg_wr_en_i && (state_q == StIdle)) begin
         inst_store[cfg_wr_addr_i] <= cfg_wr_data_i;
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         pc_q         <= '0;
         iter_q       <= '0;
         loop_start_q <= '0;
         loop_end_q   <= '0;
         loop_num_q   <= '0;
         prog_end_q   <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         ctrl_o       <= '0;
         ctrl_valid_o <= 1'b0;
         im_addr_o    <= '0;
      end else begin
         done_o       <= 1'b0;
         ctrl_valid_o <= 1'b0;
         ctrl_o       <= '0;
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  loop_start_q <= loop_start_i;
                  loop_end_q   <= loop_end_i;
                  loop_num_q   <= loop_num_i;
                  prog_end_q   <= prog_end_i;
                  pc_q         <= '0;
                  iter_q       <= '0;
                  busy_o       <= 1'b1;
                  state_q      <= StRun;
               end
            end
            StRun: begin
               if (abort_req) begin
                  busy_o  <= 1'b0;
                  state_q <= StIdle;
               end else if (issue) begin
                  ctrl_valid_o <= 1'b1;
                  ctrl_o       <= ctrl_word;
                  if (consume) begin
                     im_addr_o <= data_i;
                  end
                  // Loop back-edge has priority over program end.
                  if (take_loop) begin
                     pc_q   <= loop_start_q;
                     iter_q <= iter_inc[LoopCntWidth-1:0];
                  end else if (pc_q == prog_end_q) begin
                     busy_o  <= 1'b0;
                     done_o  <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     pc_q <= pc_inc;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_hv_encoder_seq.sv
`timescale 1ns/1ps
module tb_hv_encoder_seq;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cfg_wr_en_i = 1'b0;
   logic [3:0]  cfg_wr_addr_i = '0;
   logic [32:0] cfg_wr_data_i = '0;
   logic [3:0]  loop_start_i = '0;
   logic [3:0]  loop_end_i = '0;
   logic [15:0] loop_num_i = '0;
   logic [3:0]  prog_end_i = '0;
   logic        start_i = 1'b0;
   logic        busy_o;
   logic        done_o;
   logic        abort_i = 1'b0;
   logic        data_valid_i = 1'b0;
   logic        data_ready_o;
   logic [31:0] data_i = '0;
   logic [31:0] ctrl_o;
   logic        ctrl_valid_o;
   logic [31:0] im_addr_o;

   hv_encoder_seq dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .cfg_wr_en_i   (cfg_wr_en_i),
      .cfg_wr_addr_i (cfg_wr_addr_i),
      .cfg_wr_data_i (cfg_wr_data_i),
      .loop_start_i  (loop_start_i),
      .loop_end_i    (loop_end_i),
      .loop_num_i    (loop_num_i),
      .prog_end_i    (prog_end_i),
      .start_i       (start_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
`ifdef HV_ENCODER_SEQ_ABORT_EN
      .abort_i       (abort_i),
`endif
      .data_valid_i  (data_valid_i),
      .data_ready_o  (data_ready_o),
      .data_i        (data_i),
      .ctrl_o        (ctrl_o),
      .ctrl_valid_o  (ctrl_valid_o),
      .im_addr_o     (im_addr_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] ctrl;
      logic [31:0] im;
      logic        done;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_pop = 0;
   int          n_hs  = 0;
   logic [31:0] cur_im = '0;

   // Scoreboard monitor: every issued word is checked against the queue.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (ctrl_valid_o) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_word: ctrl=%h im=%h done=%b, none expected",
                        ctrl_o, im_addr_o, done_o);
            end else begin
               mon_e = exp_q.pop_front();
               n_pop++;
               if (ctrl_o !== mon_e.ctrl || im_addr_o !== mon_e.im || done_o !== mon_e.done) begin
                  n_err++;
                  $display("FAIL word%0d: got ctrl=%h im=%h done=%b, expected ctrl=%h im=%h done=%b",
                           n_pop, ctrl_o, im_addr_o, done_o, mon_e.ctrl, mon_e.im, mon_e.done);
               end
            end
         end else if (done_o) begin
            n_vec++;
            n_err++;
            $display("FAIL done_without_valid: done_o=1 ctrl_valid_o=0, expected done only with a word");
         end
      end
   end

   always @(posedge clk_i) begin
      if (rst_ni && data_valid_i && data_ready_o) n_hs++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] c, input logic [31:0] im, input logic d);
      exp_t e;
      e.ctrl = c;
      e.im   = im;
      e.done = d;
      exp_q.push_back(e);
   endtask

   task automatic push_loop3();
      push(32'h100, cur_im, 1'b0); push(32'h101, cur_im, 1'b0);
      push(32'h102, cur_im, 1'b0); push(32'h101, cur_im, 1'b0);
      push(32'h102, cur_im, 1'b0); push(32'h101, cur_im, 1'b0);
      push(32'h102, cur_im, 1'b0); push(32'h103, cur_im, 1'b1);
   endtask

   task automatic push_line4();
      push(32'h100, cur_im, 1'b0); push(32'h101, cur_im, 1'b0);
      push(32'h102, cur_im, 1'b0); push(32'h103, cur_im, 1'b1);
   endtask

   task automatic write_instr(input logic [3:0] a, input logic c, input logic [31:0] w);
      cfg_wr_en_i   = 1'b1;
      cfg_wr_addr_i = a;
      cfg_wr_data_i = {c, w};
      @(posedge clk_i); #1;
      cfg_wr_en_i   = 1'b0;
   endtask

   task automatic start_prog(input logic [3:0] ls, input logic [3:0] le,
                             input logic [15:0] ln, input logic [3:0] pe);
      loop_start_i = ls;
      loop_end_i   = le;
      loop_num_i   = ln;
      prog_end_i   = pe;
      start_i      = 1'b1;
      @(posedge clk_i); #1;
      start_i      = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i);
         if (done_o) begin
            seen = 1'b1;
            break;
         end
      end
      chk({name, "_done"}, {63'd0, seen}, 64'd1);
      #1;
      chk({name, "_drained"}, exp_q.size(), 64'd0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"},    busy_o,       0);
      chk({name, "_done"},    done_o,       0);
      chk({name, "_valid"},   ctrl_valid_o, 0);
      chk({name, "_ctrl"},    ctrl_o,       0);
      chk({name, "_im"},      im_addr_o,    0);
      chk({name, "_ready"},   data_ready_o, 0);
   endtask

   task automatic wait_pops(input int base, input int target);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i); #1;
         if (n_pop - base >= target) break;
      end
      chk("fifth_word_seen", {63'd0, (n_pop - base >= target)}, 64'd1);
   endtask

   initial begin
      int hs0;
      int p0;
      // Reset state
      repeat (2) @(negedge clk_i);
      chk_all_zero("reset");
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // Straight-line run: A, B, C
      write_instr(4'd0, 1'b0, 32'hA);
      write_instr(4'd1, 1'b0, 32'hB);
      write_instr(4'd2, 1'b0, 32'hC);
      push(32'hA, 32'h0, 1'b0);
      push(32'hB, 32'h0, 1'b0);
      push(32'hC, 32'h0, 1'b1);
      start_prog(4'd0, 4'd0, 16'd1, 4'd2);
      @(negedge clk_i);
      chk("line_busy_high", busy_o, 1);
      wait_done("line", 20);
      @(negedge clk_i);
      chk("line_busy_low", busy_o, 0);
      chk("line_valid_low", ctrl_valid_o, 0);

      // Loop: body 1..2 three times
      for (int i = 0; i < 4; i++) write_instr(i[3:0], 1'b0, 32'h100 + i);
      push_loop3();
      start_prog(4'd1, 4'd2, 16'd3, 4'd3);
      wait_done("loop3", 40);

      // loop_num = 0 runs the body once
      push_line4();
      start_prog(4'd1, 4'd2, 16'd0, 4'd3);
      wait_done("loop0", 40);

      // Stream stall on a consume word
      write_instr(4'd0, 1'b1, 32'h77);
      push(32'h77, 32'h55, 1'b1);
      hs0 = n_hs;
      start_prog(4'd0, 4'd0, 16'd1, 4'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("stall_valid_low", ctrl_valid_o, 0);
         chk("stall_ready_high", data_ready_o, 1);
      end
      data_i       = 32'h55;
      data_valid_i = 1'b1;
      @(posedge clk_i); #1;
      data_valid_i = 1'b0;
      data_i       = 32'h0;
      wait_done("stall", 10);
      chk("stall_handshakes", n_hs - hs0, 1);
      cur_im = 32'h55;
      @(negedge clk_i);
      chk("idle_ready_low", data_ready_o, 0);
      write_instr(4'd0, 1'b0, 32'h100);

      // start_i and cfg writes are ignored while running
      push_loop3();
      start_prog(4'd1, 4'd2, 16'd3, 4'd3);
      start_i       = 1'b1;
      prog_end_i    = 4'd0;
      loop_num_i    = 16'd0;
      cfg_wr_en_i   = 1'b1;
      cfg_wr_addr_i = 4'd0;
      cfg_wr_data_i = {1'b0, 32'hDEAD};
      @(posedge clk_i); #1;
      start_i       = 1'b0;
      cfg_wr_en_i   = 1'b0;
      wait_done("ignore", 40);
      push_line4();
      start_prog(4'd1, 4'd2, 16'd0, 4'd3);
      wait_done("entry0_kept", 40);

      // Mid-run asynchronous reset at the 5th word
      push_loop3();
      p0 = n_pop;
      start_prog(4'd1, 4'd2, 16'd3, 4'd3);
      wait_pops(p0, 5);
      rst_ni = 1'b0;
      #1;
      chk_all_zero("async_reset");
      exp_q.delete();
      cur_im = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("reset_no_done", done_o, 0);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      push_line4();
      start_prog(4'd1, 4'd2, 16'd0, 4'd3);
      wait_done("after_reset", 40);

`ifdef HV_ENCODER_SEQ_ABORT_EN
      // Abort at the 5th word
      push_loop3();
      p0 = n_pop;
      start_prog(4'd1, 4'd2, 16'd3, 4'd3);
      wait_pops(p0, 5);
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      exp_q.delete();
      @(negedge clk_i);
      chk("abort_valid_low", ctrl_valid_o, 0);
      chk("abort_busy_low", busy_o, 0);
      chk("abort_no_done", done_o, 0);
      chk("abort_ready_low", data_ready_o, 0);
      repeat (2) @(negedge clk_i);
      push_line4();
      start_prog(4'd1, 4'd2, 16'd0, 4'd3);
      wait_done("after_abort", 40);
`endif

      repeat (2) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
